// File: rtl/data_memory_unit_if.sv
// Request/response bus of the data memory: one request channel, read responses come back later.
interface data_memory_unit_if #(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 11
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ready;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
    logic                  busy;

    modport master (
        output req, we, addr, wdata,
        input  ready, rvalid, rdata, err, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output ready, rvalid, rdata, err, busy
    );
endinterface

// File: rtl/data_memory_unit.sv
// Single-port word memory: writes land at acceptance, reads answer RD_LATENCY edges later.
// Backpressure: ready drops while a read is outstanding; requests seen then are dropped, not queued.
module data_memory_unit #(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 11,
    parameter int DEPTH      = 16,
    parameter int RD_LATENCY = 2
) (
    input  logic                clock,
    input  logic                clear,
    data_memory_unit_if.slave   bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = 2;
    localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'(RD_LATENCY - 1);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      raddr_q, raddr_d;
    logic                  oor_q, oor_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  err_q, err_d;
    logic                  mem_we;
    logic                  in_range;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign in_range = ({1'b0, bus.addr} < DEPTH_L);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        raddr_d  = raddr_q;
        oor_d    = oor_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        mem_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    if (bus.we) begin
                        mem_we = in_range && clear;
                        err_d  = !in_range;
                    end else begin
                        raddr_d = bus.addr[IDX_W-1:0];
                        oor_d   = !in_range;
                        cnt_d   = CNT_LOAD;
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    // Out-of-range reads still complete on time, with zero data.
                    rdata_d  = oor_q ? '0 : mem[raddr_q];
                    rvalid_d = 1'b1;
                    err_d    = oor_q;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            raddr_q  <= '0;
            oor_q    <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            raddr_q  <= raddr_d;
            oor_q    <= oor_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    // Storage is deliberately left out of reset so a mid-read clear preserves contents.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[bus.addr[IDX_W-1:0]] <= bus.wdata;
        end
    end

    assign bus.ready  = (state_q == IDLE);
    assign bus.busy   = (state_q == RD_WAIT);
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_data_memory_unit.sv
module tb_data_memory_unit;
    logic        clock;
    logic        clear;
    logic        req;
    logic        we;
    logic [10:0] addr;
    logic [17:0] wdata;
    logic [2:0]  sel;

    logic [2:0]  rv, rdy, bsy, er;
    logic [17:0] rd [3];

    int total = 0;
    int bad   = 0;

    data_memory_unit_if bus0 ();
    data_memory_unit_if bus1 ();
    data_memory_unit_if bus2 ();

    assign bus0.req = req & sel[0];
    assign bus1.req = req & sel[1];
    assign bus2.req = req & sel[2];
    assign bus0.we = we;    assign bus1.we = we;    assign bus2.we = we;
    assign bus0.addr = addr; assign bus1.addr = addr; assign bus2.addr = addr;
    assign bus0.wdata = wdata; assign bus1.wdata = wdata; assign bus2.wdata = wdata;

    assign rv  = {bus2.rvalid, bus1.rvalid, bus0.rvalid};
    assign rdy = {bus2.ready,  bus1.ready,  bus0.ready};
    assign bsy = {bus2.busy,   bus1.busy,   bus0.busy};
    assign er  = {bus2.err,    bus1.err,    bus0.err};
    assign rd[0] = bus0.rdata;
    assign rd[1] = bus1.rdata;
    assign rd[2] = bus2.rdata;

    data_memory_unit #(.DATA_WIDTH(18), .ADDR_WIDTH(11), .DEPTH(16), .RD_LATENCY(1))
        dut_l1 (.clock(clock), .clear(clear), .bus(bus0));
    data_memory_unit #(.DATA_WIDTH(18), .ADDR_WIDTH(11), .DEPTH(16), .RD_LATENCY(2))
        dut_l2 (.clock(clock), .clear(clear), .bus(bus1));
    data_memory_unit #(.DATA_WIDTH(18), .ADDR_WIDTH(11), .DEPTH(16), .RD_LATENCY(4))
        dut_l4 (.clock(clock), .clear(clear), .bus(bus2));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered and left at posedge+1; returns the error flag seen after the acceptance edge.
    task automatic do_write(input logic [10:0] a, input logic [17:0] d, output logic e);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(posedge clock); #1;
        e = er[1];
        req = 1'b0; we = 1'b0;
    endtask

    // Counts edges from acceptance to rvalid, plus busy/not-ready samples after the intervening edges.
    task automatic do_read(input int idx, input logic [10:0] a, output logic [17:0] d,
                           output int lat, output int bcnt, output int rlo,
                           output logic e, output logic r_rdy);
        lat = -1; bcnt = 0; rlo = 0; d = 'x; e = 1'bx; r_rdy = 1'bx;
        req = 1'b1; we = 1'b0; addr = a;
        @(posedge clock); #1;
        req = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clock); #1;
            if (rv[idx]) begin
                lat = n; d = rd[idx]; e = er[idx]; r_rdy = rdy[idx];
                break;
            end
            if (bsy[idx]) bcnt++;
            if (!rdy[idx]) rlo++;
        end
    endtask

    initial begin
        logic [17:0] d;
        int          lat, bcnt, rlo, stalls, seen;
        logic        e, r_rdy;

        clear = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = 3'b010;
        #1;
        chk("rst_ready",  {31'b0, rdy[1]}, 1);
        chk("rst_busy",   {31'b0, bsy[1]}, 0);
        chk("rst_rvalid", {31'b0, rv[1]},  0);
        chk("rst_err",    {31'b0, er[1]},  0);
        chk("rst_rdata",  {14'b0, rd[1]},  0);
        @(posedge clock); #1;
        @(negedge clock);
        clear = 1'b1;

        // First request presented before the first edge after clear release.
        req = 1'b1; we = 1'b1; addr = 11'd3; wdata = 18'h2A5F3;
        @(posedge clock); #1;
        req = 1'b0; we = 1'b0;
        chk("wr3_err",    {31'b0, er[1]},  0);
        chk("wr3_rvalid", {31'b0, rv[1]},  0);
        chk("wr3_ready",  {31'b0, rdy[1]}, 1);

        do_read(1, 11'd3, d, lat, bcnt, rlo, e, r_rdy);
        chk("rd3_data",    {14'b0, d}, 18'h2A5F3);
        chk("rd3_lat",     lat, 2);
        chk("rd3_notrdy",  rlo, 1);
        chk("rd3_err",     {31'b0, e}, 0);
        chk("rd3_rdy_rsp", {31'b0, r_rdy}, 1);
        @(posedge clock); #1;
        chk("rd3_pulse",   {31'b0, rv[1]}, 0);
        chk("rd3_hold",    {14'b0, rd[1]}, 18'h2A5F3);

        // Latency sweep across the three instances.
        sel = 3'b111;
        do_write(11'd0, 18'h00111, e);
        for (int i = 0; i < 3; i++) begin
            sel = 3'b001 << i;
            do_read(i, 11'd0, d, lat, bcnt, rlo, e, r_rdy);
            chk($sformatf("sweep%0d_lat", i),  lat,  (i == 0) ? 1 : (i == 1) ? 2 : 4);
            chk($sformatf("sweep%0d_busy", i), bcnt, (i == 0) ? 0 : (i == 1) ? 1 : 3);
            chk($sformatf("sweep%0d_data", i), {14'b0, d}, 18'h00111);
        end
        sel = 3'b010;

        // Back-to-back writes with no stall.
        stalls = 0;
        req = 1'b1; we = 1'b1;
        for (int i = 0; i < 16; i++) begin
            addr = 11'(i); wdata = 18'(i * 3);
            if (!rdy[1]) stalls++;
            @(posedge clock); #1;
        end
        req = 1'b0; we = 1'b0;
        chk("b2b_stalls", stalls, 0);
        for (int i = 0; i < 16; i++) begin
            do_read(1, 11'(i), d, lat, bcnt, rlo, e, r_rdy);
            chk($sformatf("b2b_rd%0d", i), {14'b0, d}, i * 3);
            chk($sformatf("b2b_lat%0d", i), lat, 2);
        end

        // Out-of-range write and read.
        do_write(11'd20, 18'h3FFFF, e);
        chk("oor_wr_err", {31'b0, e}, 1);
        @(posedge clock); #1;
        chk("oor_wr_pulse", {31'b0, er[1]}, 0);
        do_read(1, 11'd4, d, lat, bcnt, rlo, e, r_rdy);
        chk("oor_mem4", {14'b0, d}, 12);
        do_read(1, 11'd20, d, lat, bcnt, rlo, e, r_rdy);
        chk("oor_rd_data", {14'b0, d}, 0);
        chk("oor_rd_err",  {31'b0, e}, 1);
        chk("oor_rd_lat",  lat, 2);
        @(posedge clock); #1;
        chk("oor_rd_pulse", {31'b0, er[1]}, 0);

        // Clear asserted one cycle into a read.
        do_write(11'd5, 18'h15A5A, e);
        req = 1'b1; we = 1'b0; addr = 11'd5;
        @(posedge clock); #1;
        req = 1'b0;
        @(posedge clock); #1;
        clear = 1'b0;
        #1;
        chk("mid_rst_ready",  {31'b0, rdy[1]}, 1);
        chk("mid_rst_busy",   {31'b0, bsy[1]}, 0);
        chk("mid_rst_rvalid", {31'b0, rv[1]},  0);
        chk("mid_rst_rdata",  {14'b0, rd[1]},  0);
        @(posedge clock);
        @(negedge clock);
        clear = 1'b1;
        seen = 0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clock); #1;
            if (rv[1]) seen++;
        end
        chk("mid_rst_no_rvalid", seen, 0);
        do_read(1, 11'd5, d, lat, bcnt, rlo, e, r_rdy);
        chk("mid_rst_mem5", {14'b0, d}, 18'h15A5A);

        // Write presented while busy is ignored.
        req = 1'b1; we = 1'b0; addr = 11'd9;
        @(posedge clock); #1;
        we = 1'b1; addr = 11'd7; wdata = 18'h3FFFF;
        @(posedge clock); #1;
        chk("ign_mid_rvalid", {31'b0, rv[1]}, 0);
        @(posedge clock); #1;
        req = 1'b0; we = 1'b0;
        chk("ign_rvalid", {31'b0, rv[1]}, 1);
        chk("ign_rdata",  {14'b0, rd[1]}, 27);
        chk("ign_err",    {31'b0, er[1]}, 0);
        do_read(1, 11'd7, d, lat, bcnt, rlo, e, r_rdy);
        chk("ign_mem7", {14'b0, d}, 21);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
